// File: rtl/intr_pkg.sv
// Shared types and defaults for the vectored interrupt controller.
package intr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SERV = 2'd2
  } state_e;

  localparam logic [9:0] DEF_BASE_VEC   = 10'h3F0;
  localparam int         DEF_VEC_STRIDE = 4;

  // Line index width, never narrower than one bit.
  function automatic int id_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/intr_sync_edge.sv
// Two-flop synchroniser plus history flop for one interrupt line.
module intr_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic irq_i,
  output logic edge_o,
  output logic level_o
);

  logic s1_q, s2_q, s3_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= irq_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign edge_o  = s2_q & ~s3_q;
  assign level_o = s2_q;

endmodule

// File: rtl/intr_ctrl.sv
// Vectored interrupt controller: per-line sync/pending, fixed priority
// (lowest index wins) and a req/ack/done service handshake without nesting.
module intr_ctrl
  import intr_pkg::*;
#(
  parameter int                 NUM_IRQ    = 4,
  parameter int                 VEC_W      = 10,
  parameter logic [VEC_W-1:0]   BASE_VEC   = VEC_W'(DEF_BASE_VEC),
  parameter int                 VEC_STRIDE = DEF_VEC_STRIDE,
  parameter logic [NUM_IRQ-1:0] EDGE_MASK  = {NUM_IRQ{1'b1}},
  parameter logic [NUM_IRQ-1:0] MASK_RST   = {NUM_IRQ{1'b1}},
  localparam int                ID_W       = id_width(NUM_IRQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  input  logic               irq_ack,
  input  logic               irq_done,
  output logic               irq_req,
  output logic [ID_W-1:0]    irq_id,
  output logic [VEC_W-1:0]   irq_vec,
  output logic               busy,
  output logic [NUM_IRQ-1:0] pending,
  output logic [NUM_IRQ-1:0] mask
);

  state_e               state_q, state_d;
  logic                 req_q, req_d;
  logic                 busy_q, busy_d;
  logic [ID_W-1:0]      id_q, id_d;
  logic [VEC_W-1:0]     vec_q, vec_d;
  logic [NUM_IRQ-1:0]   pending_q, pending_d;
  logic [NUM_IRQ-1:0]   mask_q, mask_d;

  logic [NUM_IRQ-1:0]   edge_w, level_w, eligible, clr_sel;
  logic [ID_W-1:0]      win_id;
  logic [VEC_W-1:0]     win_vec;
  logic                 any_elig, id_elig;

  for (genvar g = 0; g < NUM_IRQ; g++) begin : g_sync
    intr_sync_edge u_sync (
      .clk     (clk),
      .reset   (reset),
      .irq_i   (irq_in[g]),
      .edge_o  (edge_w[g]),
      .level_o (level_w[g])
    );
  end

  assign eligible = pending_q & mask_q;
  assign win_vec  = BASE_VEC + VEC_W'(win_id) * VEC_W'(VEC_STRIDE);

  // Descending scan so the lowest eligible index is the last one written.
  always_comb begin
    win_id   = '0;
    any_elig = 1'b0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        win_id   = ID_W'(i);
        any_elig = 1'b1;
      end
    end
  end

  always_comb begin
    id_elig = 1'b0;
    clr_sel = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (ID_W'(i) == id_q) begin
        id_elig    = eligible[i];
        clr_sel[i] = (state_q == ST_REQ) && irq_ack;
      end
    end
  end

  // Edge lines: a new edge beats the ack clear; level lines just follow s2.
  always_comb begin
    pending_d = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (EDGE_MASK[i]) pending_d[i] = edge_w[i] | (pending_q[i] & ~clr_sel[i]);
      else              pending_d[i] = level_w[i];
    end
  end

  assign mask_d = mask_we ? mask_wdata : mask_q;

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    busy_d  = busy_q;
    id_d    = id_q;
    vec_d   = vec_q;
    case (state_q)
      ST_IDLE: begin
        if (any_elig) begin
          id_d    = win_id;
          vec_d   = win_vec;
          req_d   = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (irq_ack) begin
          req_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = ST_SERV;
        end else if (!id_elig) begin
          req_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      ST_SERV: begin
        if (irq_done) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        req_d   = 1'b0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      req_q     <= 1'b0;
      busy_q    <= 1'b0;
      id_q      <= '0;
      vec_q     <= '0;
      pending_q <= '0;
      mask_q    <= MASK_RST;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      busy_q    <= busy_d;
      id_q      <= id_d;
      vec_q     <= vec_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
    end
  end

  assign irq_req = req_q;
  assign irq_id  = id_q;
  assign irq_vec = vec_q;
  assign busy    = busy_q;
  assign pending = pending_q;
  assign mask    = mask_q;

endmodule
